// File: rtl/multdiv_seq_if.sv
// Operand, start and result handshake bundle for the iterative multiply/divide unit.
// The master side is the execute stage and the slave side is the unit itself.
interface multdiv_seq_if #(
  parameter int WIDTH = 32,
  parameter int IMM_W = 17
);
  logic             ctrl_mult;
  logic             ctrl_div;
  logic             use_imm;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic [IMM_W-1:0] imm;
  logic [WIDTH-1:0] result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_mult, ctrl_div, use_imm, data_a, data_b, imm,
    input  result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_mult, ctrl_div, use_imm, data_a, data_b, imm,
    output result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/multdiv_seq.sv
// Iterative signed multiply (shift/add) and divide (restoring shift/subtract) unit.
// Both paths work on operand magnitudes and apply the result sign on the final iteration.
module multdiv_seq #(
  parameter int WIDTH = 32,
  parameter int IMM_W = 17
) (
  input  logic          clock,
  input  logic          resetn,
  multdiv_seq_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int W2    = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [WIDTH-1:0] result_q, result_d;
  logic                    exc_q, exc_d;

  logic [W2-1:0]           p_q, p_d, mcand_q, mcand_d;
  logic [WIDTH-1:0]        mplier_q, mplier_d;
  logic [WIDTH-1:0]        rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic                    neg_q, neg_d, ovf_q, ovf_d;

  logic [WIDTH-1:0]        b_sel;
  logic [W2-1:0]           prod;
  logic [WIDTH:0]          rem_sh, diff;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [W2-1:0] neg_w2(input logic [W2-1:0] v);
    return ~v + W2'(1);
  endfunction

  assign b_sel = bus.use_imm ? {{(WIDTH-IMM_W){bus.imm[IMM_W-1]}}, bus.imm} : bus.data_b;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    exc_d    = exc_q;
    p_d      = p_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    prod     = '0;
    rem_sh   = '0;
    diff     = '0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.ctrl_mult) begin
          state_d  = S_MULT;
          cnt_d    = '0;
          p_d      = '0;
          mcand_d  = {{WIDTH{1'b0}}, mag(bus.data_a)};
          mplier_d = mag(b_sel);
          neg_d    = bus.data_a[WIDTH-1] ^ b_sel[WIDTH-1];
        end else if (bus.ctrl_div) begin
          if (b_sel == '0) begin
            state_d  = S_DONE;
            result_d = '0;
            exc_d    = 1'b1;
          end else begin
            state_d = S_DIV;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = mag(bus.data_a);
            dvsr_d  = mag(b_sel);
            neg_d   = bus.data_a[WIDTH-1] ^ b_sel[WIDTH-1];
            // Most-negative / -1 cannot be represented; flag it up front.
            ovf_d   = (bus.data_a == {1'b1, {(WIDTH-1){1'b0}}}) && (b_sel == '1);
          end
        end
      end

      S_MULT: begin
        p_d      = p_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          state_d  = S_DONE;
          prod     = neg_q ? neg_w2(p_d) : p_d;
          result_d = prod[WIDTH-1:0];
          exc_d    = prod[W2-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
        end
      end

      S_DIV: begin
        // Remainder stays below the divisor, so WIDTH+1 bits hold the shifted trial value.
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, dvsr_q};
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          state_d = S_DONE;
          if (ovf_q) begin
            result_d = {1'b1, {(WIDTH-1){1'b0}}};
            exc_d    = 1'b1;
          end else begin
            result_d = neg_q ? (~quo_d + WIDTH'(1)) : quo_d;
            exc_d    = 1'b0;
          end
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  // Iteration datapath needs no reset: it is always loaded before use.
  always_ff @(posedge clock) begin
    p_q      <= p_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    rem_q    <= rem_d;
    quo_q    <= quo_d;
    dvsr_q   <= dvsr_d;
    neg_q    <= neg_d;
    ovf_q    <= ovf_d;
  end

  assign bus.result         = result_q;
  assign bus.data_resultRDY = (state_q == S_DONE);
  assign bus.data_exception = (state_q == S_DONE) && exc_q;
  assign bus.busy           = (state_q == S_MULT) || (state_q == S_DIV);
endmodule

// File: doc/multdiv_seq.md
Name: multdiv_seq

Overview:
- Iterative signed 32-bit multiply/divide unit with its own sequencer, used by the execute stage for mul/div instructions.
- Latches operand A and operand B on a start pulse. Operand B is either a register value or a 17-bit immediate, sign-extended internally.
- Runs WIDTH shift/add (mult) or shift/subtract (div) iterations, then returns the result with a one-cycle ready strobe.
- While the unit is busy, the pipeline stalls on `busy`.

Parameters:
- WIDTH, 32, operand/result width; also the iteration count.
- IMM_W, 17, immediate width; sign-extended to WIDTH using bit IMM_W-1.

Ports:
- clock  input  1  rising-edge clock
- resetn  input  1  asynchronous active-low reset
- ctrl_mult  input  1  start-multiply pulse, sampled on rising edge
- ctrl_div  input  1  start-divide pulse, sampled on rising edge
- use_imm  input  1  1: operand B = sign-extended imm; 0: operand B = data_b
- data_a  input  WIDTH  operand A (multiplicand / dividend), signed
- data_b  input  WIDTH  operand B (multiplier / divisor), signed
- imm  input  IMM_W  immediate operand
- result  output  WIDTH  product low WIDTH bits, or quotient
- data_exception  output  1  mult overflow or divide-by-zero; valid while data_resultRDY=1
- data_resultRDY  output  1  one-cycle result-valid strobe
- busy  output  1  high in MULT/DIV states

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE; counter=0; result=0; data_exception=0; data_resultRDY=0; busy=0. Reset mid-operation aborts with no RDY strobe.
- States are IDLE, MULT, DIV, DONE.
  - data_resultRDY = (state==DONE).
  - busy = (state==MULT or DIV).
- Operand B select: B = use_imm ? {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm} : data_b. Selection happens at the sampling edge only.
- IDLE:
  - ctrl_mult=1 -> MULT. Latch A and B, clear counter and partial product.
  - ctrl_div=1 (with ctrl_mult=0) -> DIV, with the same latching.
  - ctrl_mult and ctrl_div both 1: multiply wins.
  - Divide with B==0 at the sampling edge -> DONE directly. result=0, exception=1.
- MULT:
  - One iteration per edge; counter increments.
  - On the edge where counter reaches WIDTH -> DONE.
  - result = low WIDTH bits of the signed 2WIDTH-bit product.
  - exception=1 iff the high WIDTH bits are not all equal to result[WIDTH-1].
- DIV:
  - Operands are converted to magnitudes at latch time; the unsigned restoring divide runs WIDTH iterations, then -> DONE.
  - Quotient is negated if sign(A)!=sign(B). Truncation is toward zero; the remainder is discarded.
  - Special case A=-2^(WIDTH-1), B=-1: result=A, exception=1.
  - Otherwise exception=0.
- DONE: lasts exactly one cycle, then -> IDLE. result holds its value until the next operation completes.
- Latency: with the start sampled at edge 0, data_resultRDY is high in the cycle following edge WIDTH (edge 32 at default). Divide-by-zero is the exception: RDY is high in the cycle following edge 0.
- ctrl_mult/ctrl_div while busy or in DONE are ignored; no queuing. A start pulse in IDLE is accepted even when RDY was high the previous cycle.
- data_exception is driven 0 whenever state!=DONE.

Test Plan:
- Reset, then A=7, B=-3 (use_imm=0), ctrl_mult pulse -> busy high for 32 cycles; RDY for exactly 1 cycle after edge 32; result=-21 (0xFFFFFFEB), exception=0.
- use_imm=1, imm=17'h1FFFF, A=100, ctrl_mult -> result=-100; with imm=17'h0FFFF -> result=6553500.
- A=0x40000000, B=4, ctrl_mult -> result=0, exception=1. A=-7, B=2, ctrl_div -> result=-3, exception=0.
- A=5, B=0, ctrl_div -> RDY in the cycle after the sampling edge, result=0, exception=1, busy never high. A=0x80000000, B=-1, ctrl_div -> result=0x80000000, exception=1.
- ctrl_mult and ctrl_div together -> multiply performed. A second ctrl_div pulse at cycle 10 of a multiply is ignored: exactly one RDY, with the product.
- resetn low at cycle 15 of a divide -> outputs 0 immediately, no RDY. A new ctrl_mult after release completes normally.
